// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset and lock supervisor on refclk.
// Sequences PLL reset, qualifies lock, releases system reset.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 125000,
  parameter int LOCK_FILTER    = 64,
  parameter int HOLD_CYCLES    = 256,
  parameter int MAX_RETRY      = 3,
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          soft_rst_req,
  output logic          pll_rst,
  output logic          sys_rst_n,
  output logic          lock_lost,
  output logic          fault,
  output logic [RW-1:0] retry_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = max2(
    max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
    max2(max2(LOCK_FILTER, HOLD_CYCLES), 2));
  // +1 so the filter terminal count LOCK_FILTER fits
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_RST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_FILT = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] C_MR   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_FILTER,
    S_HOLD,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync1;
  logic          r_locked_s;
  logic          r_pll_rst;
  logic          r_sys_rst_n;
  logic          r_lock_lost;
  logic          r_fault;
  logic [RW-1:0] r_retry;
  logic [CW-1:0] w_cnt_inc;
  logic [RW-1:0] w_retry_inc;

  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_retry_inc = r_retry + 1'b1;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fault     <= 1'b0;
      r_retry     <= '0;
    end else begin
      r_lock_lost <= 1'b0;
      r_cnt       <= w_cnt_inc;
      unique case (r_state)
        S_PLL_RST: begin
          if (r_cnt == C_RST) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          if (r_locked_s) begin
            r_state <= S_FILTER;
            r_cnt   <= '0;
          end else if (r_cnt == C_TMO) begin
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (r_retry == C_MR) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_PLL_RST;
              r_retry <= w_retry_inc;
            end
          end
        end
        S_FILTER: begin
          // a dropout restarts the lock wait without a retry
          if (!r_locked_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == C_FILT) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end
        end
        S_HOLD: begin
          if (!r_locked_s) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_lock_lost <= 1'b1;
            r_retry     <= '0;
          end else if (r_cnt == C_HOLD) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b1;
            r_retry     <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= '0;
          if (!r_locked_s) begin
            r_state     <= S_PLL_RST;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_lock_lost <= 1'b1;
          end else if (soft_rst_req) begin
            r_state     <= S_PLL_RST;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
          end
        end
        S_FAULT: begin
          r_cnt <= '0;
          if (soft_rst_req) begin
            r_state <= S_PLL_RST;
            r_fault <= 1'b0;
            r_retry <= '0;
          end
        end
        default: begin
          r_state     <= S_PLL_RST;
          r_cnt       <= '0;
          r_pll_rst   <= 1'b1;
          r_sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst_n   = r_sys_rst_n;
  assign lock_lost   = r_lock_lost;
  assign fault       = r_fault;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard bench for pll_reset_sequencer.
// Expected event edges are queued at stimulus time, popped on DUT events.
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LT  = 100;
  localparam int LF  = 8;
  localparam int HC  = 16;
  localparam int MR  = 2;
  localparam int RW  = $clog2(MR + 1);
  // edges from driving pll_locked at a negedge to sys_rst_n rise
  localparam int UP  = 4 + LF + HC;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pll_locked = 1'b0;
  logic          soft_rst_req = 1'b0;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          lock_lost;
  logic          fault;
  logic [RW-1:0] retry_count;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int   cyc;
    logic val;
    int   rc;
  } exp_t;

  exp_t q[$];

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LT),
    .LOCK_FILTER   (LF),
    .HOLD_CYCLES   (HC),
    .MAX_RETRY     (MR)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_rst_req(soft_rst_req),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .lock_lost   (lock_lost),
    .fault       (fault),
    .retry_count (retry_count)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic nclk(input int n);
    repeat (n) @(negedge refclk);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return pll_rst;
      1:       return sys_rst_n;
      2:       return lock_lost;
      default: return fault;
    endcase
  endfunction

  task automatic wait_sig(input int w, input logic v,
                          input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge refclk);
      if (sig(w) === v) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic hard_reset();
    @(negedge refclk);
    rst_n = 1'b0;
    pll_locked = 1'b0;
    soft_rst_req = 1'b0;
    nclk(2);
    rst_n = 1'b1;
  endtask

  task automatic bring_to_run();
    int at;
    hard_reset();
    wait_sig(0, 1'b0, 20, at);
    nclk(2);
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, 100, at);
    nclk(3);
  endtask

  task automatic test_reset();
    @(negedge refclk);
    rst_n = 1'b0;
    nclk(2);
    n_chk++;
    if (pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pll_rst got %b want 1", pll_rst);
    end
    n_chk++;
    if (sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n);
    end
    n_chk++;
    if (lock_lost !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b%b want 00",
               lock_lost, fault);
    end
    n_chk++;
    if (retry_count !== '0) begin
      n_fail++;
      $display("FAIL reset_retry got %0d want 0", retry_count);
    end
  endtask

  task automatic test_bring_up();
    int at;
    exp_t e;
    hard_reset();
    q.push_back(exp_t'{cyc + PRC, 1'b0, 0});
    wait_sig(0, 1'b0, 20, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL bringup_pll_rst_fall got %0d want %0d",
               at, e.cyc);
    end
    nclk(10);
    pll_locked = 1'b1;
    q.push_back(exp_t'{cyc + UP, 1'b1, 0});
    wait_sig(1, 1'b1, 100, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL bringup_sys_rst_rise got %0d want %0d",
               at, e.cyc);
    end
    n_chk++;
    if (retry_count !== '0 || fault !== 1'b0 || pll_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL bringup_status got rc=%0d f=%b p=%b want 0 0 0",
               retry_count, fault, pll_rst);
    end
  endtask

  task automatic test_glitch();
    int at;
    exp_t e;
    hard_reset();
    wait_sig(0, 1'b0, 20, at);
    nclk(3);
    pll_locked = 1'b1;
    nclk(5);
    pll_locked = 1'b0;
    nclk(1);
    pll_locked = 1'b1;
    q.push_back(exp_t'{cyc + UP, 1'b1, 0});
    wait_sig(1, 1'b1, 100, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL glitch_sys_rst_rise got %0d want %0d",
               at, e.cyc);
    end
    n_chk++;
    if (retry_count !== '0 || pll_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_no_retry got rc=%0d p=%b want 0 0",
               retry_count, pll_rst);
    end
  endtask

  task automatic test_timeout_fault();
    int at;
    int c0;
    int d;
    exp_t e;
    hard_reset();
    c0 = cyc;
    q.push_back(exp_t'{c0 + PRC,          1'b0, 0});
    q.push_back(exp_t'{c0 + PRC + LT,     1'b1, 1});
    q.push_back(exp_t'{c0 + 2*PRC + LT,   1'b0, 1});
    q.push_back(exp_t'{c0 + 2*PRC + 2*LT, 1'b1, 2});
    q.push_back(exp_t'{c0 + 3*PRC + 2*LT, 1'b0, 2});
    q.push_back(exp_t'{c0 + 3*PRC + 3*LT, 1'b1, 2});
    while (q.size() > 0) begin
      e = q.pop_front();
      wait_sig(0, e.val, 150, at);
      n_chk++;
      if (at !== e.cyc || int'(retry_count) !== e.rc) begin
        n_fail++;
        $display("FAIL timeout_pll_rst_%b got @%0d rc=%0d want @%0d rc=%0d",
                 e.val, at, retry_count, e.cyc, e.rc);
      end
    end
    n_chk++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fault_set got %b want 1", fault);
    end
    nclk(20);
    n_chk++;
    if (fault !== 1'b1 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_sticky got f=%b p=%b s=%b want 1 1 0",
               fault, pll_rst, sys_rst_n);
    end
    soft_rst_req = 1'b1;
    d = cyc;
    nclk(1);
    soft_rst_req = 1'b0;
    n_chk++;
    if (fault !== 1'b0 || retry_count !== '0 || pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clear got f=%b rc=%0d p=%b want 0 0 1",
               fault, retry_count, pll_rst);
    end
    q.push_back(exp_t'{d + 1 + PRC, 1'b0, 0});
    wait_sig(0, 1'b0, 20, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL fault_restart_pll_rst_fall got %0d want %0d",
               at, e.cyc);
    end
    nclk(2);
    pll_locked = 1'b1;
    q.push_back(exp_t'{cyc + UP, 1'b1, 0});
    wait_sig(1, 1'b1, 100, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL fault_rebringup got %0d want %0d", at, e.cyc);
    end
  endtask

  task automatic test_lock_loss();
    int at;
    int c;
    exp_t e;
    bring_to_run();
    pll_locked = 1'b0;
    c = cyc;
    q.push_back(exp_t'{c + 3, 1'b1, 0});
    wait_sig(2, 1'b1, 20, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL loss_pulse_edge got %0d want %0d", at, e.cyc);
    end
    n_chk++;
    if (sys_rst_n !== 1'b0 || pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_outputs got s=%b p=%b want 0 1",
               sys_rst_n, pll_rst);
    end
    nclk(1);
    n_chk++;
    if (lock_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_pulse_width got %b want 0", lock_lost);
    end
    q.push_back(exp_t'{c + 3 + PRC, 1'b0, 0});
    wait_sig(0, 1'b0, 20, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL loss_pll_rst_fall got %0d want %0d", at, e.cyc);
    end
    nclk(2);
    pll_locked = 1'b1;
    q.push_back(exp_t'{cyc + UP, 1'b1, 0});
    wait_sig(1, 1'b1, 100, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL loss_resequence got %0d want %0d", at, e.cyc);
    end
  endtask

  task automatic test_simultaneous();
    int at;
    int c;
    exp_t e;
    bring_to_run();
    pll_locked = 1'b0;
    c = cyc;
    nclk(2);
    soft_rst_req = 1'b1;
    q.push_back(exp_t'{c + 3, 1'b1, 0});
    wait_sig(2, 1'b1, 10, at);
    soft_rst_req = 1'b0;
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL simul_lock_lost got %0d want %0d", at, e.cyc);
    end
    bring_to_run();
    soft_rst_req = 1'b1;
    nclk(1);
    soft_rst_req = 1'b0;
    n_chk++;
    if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || lock_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_run got p=%b s=%b l=%b want 1 0 0",
               pll_rst, sys_rst_n, lock_lost);
    end
    hard_reset();
    wait_sig(0, 1'b0, 20, at);
    nclk(2);
    pll_locked = 1'b1;
    q.push_back(exp_t'{cyc + UP, 1'b1, 0});
    nclk(15);
    soft_rst_req = 1'b1;
    nclk(3);
    soft_rst_req = 1'b0;
    n_chk++;
    if (pll_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_hold_pll_rst got %b want 0", pll_rst);
    end
    wait_sig(1, 1'b1, 50, at);
    e = q.pop_front();
    n_chk++;
    if (at !== e.cyc) begin
      n_fail++;
      $display("FAIL soft_hold_ignored got %0d want %0d", at, e.cyc);
    end
  endtask

  task automatic test_mid_reset();
    int at;
    hard_reset();
    wait_sig(0, 1'b0, 20, at);
    nclk(2);
    pll_locked = 1'b1;
    nclk(20);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_resets got p=%b s=%b want 1 0",
               pll_rst, sys_rst_n);
    end
    n_chk++;
    if (lock_lost !== 1'b0 || fault !== 1'b0 || retry_count !== '0) begin
      n_fail++;
      $display("FAIL midrst_flags got l=%b f=%b rc=%0d want 0 0 0",
               lock_lost, fault, retry_count);
    end
    nclk(2);
    rst_n = 1'b1;
    pll_locked = 1'b0;
    nclk(2);
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_glitch();
    test_timeout_fault();
    test_lock_loss();
    test_simultaneous();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
